watch_set_core: RTL and testbench

//  Parametrised real-time-clock core: sub-second/sec/min/hour counters driven from a clock prescaler.

---
 rtl/watch_pkg.sv | 45 ++++
 rtl/watch_tick_gen.sv | 31 +++
 rtl/watch_set_core.sv | 169 ++++++++++++++++
 tb/tb_watch_set_core.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared encodings and wrap helpers for the watch core.
// Pure declarations; no timing and no flow control.
package watch_pkg;

    typedef enum logic [1:0] {
        FLD_SEC  = 2'd0,
        FLD_MIN  = 2'd1,
        FLD_HOUR = 2'd2
    } field_t;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_t;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    function automatic logic [5:0] wrap_inc6(input logic [5:0] v, input logic [5:0] vmax);
        return (v == vmax) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] wrap_dec6(input logic [5:0] v, input logic [5:0] vmax);
        return (v == 6'd0) ? vmax : v - 6'd1;
    endfunction

    // Cursor rotation: right walks SEC->MIN->HOUR->SEC, left walks the reverse.
    function automatic field_t fld_right(input field_t f);
        case (f)
            FLD_SEC: return FLD_MIN;
            FLD_MIN: return FLD_HOUR;
            default: return FLD_SEC;
        endcase
    endfunction

    function automatic field_t fld_left(input field_t f);
        case (f)
            FLD_SEC:  return FLD_HOUR;
            FLD_HOUR: return FLD_MIN;
            default:  return FLD_SEC;
        endcase
    endfunction

endpackage

// File: rtl/watch_tick_gen.sv
// Clock prescaler: one-cycle tick when the count reaches CLK_HZ/TICK_HZ-1.
// Tick is decoded from the count register; hold clears and freezes the count.
module watch_tick_gen #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    output logic tick
);

    localparam int DIV   = (CLK_HZ / TICK_HZ > 0) ? CLK_HZ / TICK_HZ : 1;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (hold || (r_cnt == TERM)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tick = !hold && (r_cnt == TERM);

endmodule

// File: rtl/watch_set_core.sv
// Real-time clock with SET mode: cursor, per-field up/down adjust, 12/24 h display.
// Field adjust lands one edge after the button pulse; no backpressure, pulses always consumed.
module watch_set_core
    import watch_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TICK_HZ    = 100,
    parameter int SUBSEC_W   = 7,
    parameter int BLINK_HZ   = 2,
    parameter int RESET_HOUR = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sw_set,
    input  logic                mode_12h,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                btn_up,
    input  logic                btn_down,
    output logic [SUBSEC_W-1:0] subsec,
    output logic [5:0]          sec,
    output logic [5:0]          min,
    output logic [4:0]          hour,
    output logic [4:0]          hour_disp,
    output logic                pm,
    output logic [2:0]          cursor,
    output logic                blink
);

    localparam logic [SUBSEC_W-1:0] SUB_TERM = SUBSEC_W'(TICK_HZ - 1);
    localparam logic [5:0] SEC_TOP  = 6'(SEC_MAX);
    localparam logic [5:0] MIN_TOP  = 6'(MIN_MAX);
    localparam logic [4:0] HOUR_TOP = 5'(HOUR_MAX);
    localparam int BLK_HALF = (TICK_HZ / (2 * BLINK_HZ) > 0) ? TICK_HZ / (2 * BLINK_HZ) : 1;
    localparam int BLK_W    = (BLK_HALF > 1) ? $clog2(BLK_HALF) : 1;
    localparam logic [BLK_W-1:0] BLK_TERM = BLK_W'(BLK_HALF - 1);

    state_t              r_state;
    field_t              r_field;
    logic [SUBSEC_W-1:0] r_subsec;
    logic [5:0]          r_sec;
    logic [5:0]          r_min;
    logic [4:0]          r_hour;
    logic                r_blink;
    logic [BLK_W-1:0]    r_blk_cnt;

    logic       w_hold;
    logic       w_run_tick;
    logic       w_free_tick;
    logic       w_blk_toggle;
    logic       w_adj_up;
    logic       w_adj_dn;
    logic       w_mv_r;
    logic       w_mv_l;
    logic [4:0] w_hour_inc;
    logic [4:0] w_hour_dec;
    logic [4:0] w_hour12;

    assign w_hold = (r_state == ST_SET);

    watch_tick_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_run_tick (
        .clk  (clk),
        .rst  (rst),
        .hold (w_hold),
        .tick (w_run_tick)
    );

    // Blink phase follows an un-held prescaler so SET entry does not restart it.
    watch_tick_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_free_tick (
        .clk  (clk),
        .rst  (rst),
        .hold (1'b0),
        .tick (w_free_tick)
    );

    assign w_blk_toggle = w_free_tick && (r_blk_cnt == BLK_TERM);
    assign w_adj_up     = btn_up && !btn_down;
    assign w_adj_dn     = btn_down && !btn_up;
    assign w_mv_r       = btn_right && !btn_left;
    assign w_mv_l       = btn_left && !btn_right;
    assign w_hour_inc   = (r_hour == HOUR_TOP) ? 5'd0 : r_hour + 5'd1;
    assign w_hour_dec   = (r_hour == 5'd0) ? HOUR_TOP : r_hour - 5'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_RUN;
            r_field   <= FLD_SEC;
            r_subsec  <= '0;
            r_sec     <= 6'd0;
            r_min     <= 6'd0;
            r_hour    <= 5'(RESET_HOUR);
            r_blink   <= 1'b1;
            r_blk_cnt <= '0;
        end else begin
            if (w_free_tick) begin
                r_blk_cnt <= (r_blk_cnt == BLK_TERM) ? '0 : r_blk_cnt + BLK_W'(1);
            end
            r_blink <= (r_state == ST_SET && sw_set) ? (r_blink ^ w_blk_toggle) : 1'b1;

            case (r_state)
                ST_RUN: begin
                    if (w_run_tick) begin
                        if (r_subsec == SUB_TERM) begin
                            r_subsec <= '0;
                            if (r_sec == SEC_TOP) begin
                                r_sec <= 6'd0;
                                if (r_min == MIN_TOP) begin
                                    r_min  <= 6'd0;
                                    r_hour <= w_hour_inc;
                                end else begin
                                    r_min <= r_min + 6'd1;
                                end
                            end else begin
                                r_sec <= r_sec + 6'd1;
                            end
                        end else begin
                            r_subsec <= r_subsec + SUBSEC_W'(1);
                        end
                    end
                    if (sw_set) begin
                        r_state <= ST_SET;
                    end
                end
                ST_SET: begin
                    // Adjust uses the pre-move cursor; the move lands on the same edge.
                    if (w_adj_up || w_adj_dn) begin
                        r_subsec <= '0;
                        case (r_field)
                            FLD_SEC:  r_sec  <= w_adj_up ? wrap_inc6(r_sec, SEC_TOP) : wrap_dec6(r_sec, SEC_TOP);
                            FLD_MIN:  r_min  <= w_adj_up ? wrap_inc6(r_min, MIN_TOP) : wrap_dec6(r_min, MIN_TOP);
                            FLD_HOUR: r_hour <= w_adj_up ? w_hour_inc : w_hour_dec;
                            default:  r_field <= FLD_SEC;
                        endcase
                    end
                    if (w_mv_r) begin
                        r_field <= fld_right(r_field);
                    end else if (w_mv_l) begin
                        r_field <= fld_left(r_field);
                    end
                    if (!sw_set) begin
                        r_state  <= ST_RUN;
                        r_subsec <= '0;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    always_comb begin
        w_hour12 = r_hour;
        if (r_hour == 5'd0) begin
            w_hour12 = 5'd12;
        end else if (r_hour > 5'd12) begin
            w_hour12 = r_hour - 5'd12;
        end
    end

    assign subsec    = r_subsec;
    assign sec       = r_sec;
    assign min       = r_min;
    assign hour      = r_hour;
    assign blink     = r_blink;
    assign pm        = (r_hour >= 5'd12);
    assign hour_disp = mode_12h ? w_hour12 : r_hour;
    assign cursor    = (r_state == ST_SET) ?
                       {r_field == FLD_HOUR, r_field == FLD_MIN, r_field == FLD_SEC} : 3'b000;

endmodule

// File: tb/tb_watch_set_core.sv
// Directed plus randomized bench for watch_set_core against a time-of-day reference model.
module tb_watch_set_core;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 10;
    localparam int BLINK   = 1;
    localparam int SW      = 4;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int HALF    = DIV * (TICK_HZ / (2 * BLINK));
    localparam int DAY     = 24 * 3600 * TICK_HZ;

    logic          clk = 1'b0;
    logic          rst;
    logic          sw_set, mode_12h, btn_left, btn_right, btn_up, btn_down;
    logic [SW-1:0] subsec;
    logic [5:0]    sec, min;
    logic [4:0]    hour, hour_disp;
    logic          pm, blink;
    logic [2:0]    cursor;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: time of day as a count of sub-second units.
    int m_tot, m_cur, m_set, m_blink, m_g, m_run;

    watch_set_core #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .SUBSEC_W(SW), .BLINK_HZ(BLINK), .RESET_HOUR(12)
    ) dut (
        .clk(clk), .rst(rst), .sw_set(sw_set), .mode_12h(mode_12h),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
        .subsec(subsec), .sec(sec), .min(min), .hour(hour), .hour_disp(hour_disp),
        .pm(pm), .cursor(cursor), .blink(blink)
    );

    always #5 clk = ~clk;

    function automatic int m_sub();  return m_tot % TICK_HZ; endfunction
    function automatic int m_sec();  return (m_tot / TICK_HZ) % 60; endfunction
    function automatic int m_min();  return (m_tot / (TICK_HZ * 60)) % 60; endfunction
    function automatic int m_hour(); return m_tot / (TICK_HZ * 3600); endfunction

    function automatic int m_hdisp();
        int h;
        h = m_hour();
        if (!mode_12h) return h;
        if (h == 0)    return 12;
        if (h > 12)    return h - 12;
        return h;
    endfunction

    task automatic model_reset();
        m_tot = 12 * 3600 * TICK_HZ;
        m_cur = 0; m_set = 0; m_blink = 1; m_g = 0; m_run = 0;
    endtask

    task automatic model_step(input bit s, input bit l, input bit r, input bit u, input bit d);
        int hh, mm, ss;
        m_g++;
        m_blink = (m_set && s) ? ((m_g % HALF == 0) ? 1 - m_blink : m_blink) : 1;
        if (!m_set) begin
            m_run++;
            if (m_run % DIV == 0) m_tot = (m_tot + 1) % DAY;
            if (s) m_set = 1;
        end else begin
            if (u != d) begin
                hh = m_hour(); mm = m_min(); ss = m_sec();
                case (m_cur)
                    0: ss = (ss + (u ? 1 : 59)) % 60;
                    1: mm = (mm + (u ? 1 : 59)) % 60;
                    default: hh = (hh + (u ? 1 : 23)) % 24;
                endcase
                m_tot = ((hh * 60 + mm) * 60 + ss) * TICK_HZ;
            end
            if (l != r) m_cur = r ? (m_cur + 1) % 3 : (m_cur + 2) % 3;
            if (!s) begin
                m_set = 0;
                m_tot = m_tot - m_sub();
                m_run = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".subsec"}, 32'(subsec), 32'(m_sub()));
        chk({tag, ".sec"},    32'(sec),    32'(m_sec()));
        chk({tag, ".min"},    32'(min),    32'(m_min()));
        chk({tag, ".hour"},   32'(hour),   32'(m_hour()));
        chk({tag, ".hdisp"},  32'(hour_disp), 32'(m_hdisp()));
        chk({tag, ".pm"},     32'(pm),     32'(m_hour() >= 12));
        chk({tag, ".cursor"}, 32'(cursor), m_set ? 32'(1 << m_cur) : 32'd0);
        chk({tag, ".blink"},  32'(blink),  32'(m_blink));
    endtask

    task automatic cyc();
        bit s, l, r, u, d;
        s = sw_set; l = btn_left; r = btn_right; u = btn_up; d = btn_down;
        @(posedge clk);
        #1;
        model_step(s, l, r, u, d);
        btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    endtask

    task automatic press(input bit l, input bit r, input bit u, input bit d);
        btn_left = l; btn_right = r; btn_up = u; btn_down = d;
        cyc();
    endtask

    initial begin
        logic [3:0] rb;
        logic       pb;
        logic [5:0] prev_sec;
        int tog_n, tog_a, tog_b, wait_n;

        rst = 1'b0; sw_set = 1'b0; mode_12h = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        // 1. reset state and first second
        chk("rst.hour", 32'(hour), 32'd12);
        chk("rst.hdisp", 32'(hour_disp), 32'd12);
        chk("rst.pm", 32'(pm), 32'd1);
        chk("rst.cursor", 32'(cursor), 32'd0);
        chk("rst.blink", 32'(blink), 32'd1);
        check_all("rst");
        rst = 1'b1;
        repeat (DIV * TICK_HZ - 1) cyc();
        chk("t1.pre_sec", 32'(sec), 32'd0);
        chk("t1.pre_sub", 32'(subsec), 32'(TICK_HZ - 1));
        cyc();
        chk("t1.sec", 32'(sec), 32'd1);
        chk("t1.sub", 32'(subsec), 32'd0);
        check_all("t1");

        // 2. preload 23:59:59.9 through SET, then midnight wrap
        sw_set = 1'b1; cyc();
        press(0, 0, 0, 1); press(0, 0, 0, 1);
        press(0, 1, 0, 0); press(0, 0, 0, 1);
        press(0, 1, 0, 0);
        repeat (11) press(0, 0, 1, 0);
        sw_set = 1'b0; cyc();
        repeat (DIV * (TICK_HZ - 1)) cyc();
        chk("t2.hour", 32'(hour), 32'd23);
        chk("t2.min", 32'(min), 32'd59);
        chk("t2.sec", 32'(sec), 32'd59);
        chk("t2.sub", 32'(subsec), 32'(TICK_HZ - 1));
        mode_12h = 1'b1; #1;
        chk("t2.hdisp11", 32'(hour_disp), 32'd11);
        check_all("t2pre");
        repeat (DIV) cyc();
        chk("t2.wrap_hour", 32'(hour), 32'd0);
        chk("t2.wrap_sec", 32'(sec), 32'd0);
        chk("t2.hdisp12", 32'(hour_disp), 32'd12);
        chk("t2.pm", 32'(pm), 32'd0);
        check_all("t2");

        // 3. per-field wraps without carry; cursor retained on HOUR
        sw_set = 1'b1; cyc();
        chk("t3.cursor_kept", 32'(cursor), 32'b100);
        press(0, 0, 0, 1);
        chk("t3.hour_dn", 32'(hour), 32'd23);
        press(0, 1, 0, 0); press(0, 0, 0, 1);
        chk("t3.sec_dn", 32'(sec), 32'd59);
        press(0, 1, 0, 0); press(0, 0, 0, 1); press(0, 0, 1, 0);
        chk("t3.min_up", 32'(min), 32'd0);
        chk("t3.hour_same", 32'(hour), 32'd23);
        check_all("t3");

        // 4. cursor rotation and simultaneous pulses
        press(1, 0, 0, 0);
        chk("t4.left_sec", 32'(cursor), 32'b001);
        press(0, 1, 0, 0); chk("t4.r1", 32'(cursor), 32'b010);
        press(0, 1, 0, 0); chk("t4.r2", 32'(cursor), 32'b100);
        press(0, 1, 0, 0); chk("t4.r3", 32'(cursor), 32'b001);
        press(1, 0, 0, 0); chk("t4.l1", 32'(cursor), 32'b100);
        press(0, 0, 1, 1); chk("t4.updn", 32'(hour), 32'd23);
        press(1, 1, 0, 0); chk("t4.lr", 32'(cursor), 32'b100);
        press(0, 1, 1, 0);
        chk("t4.mvadj_hour", 32'(hour), 32'd0);
        chk("t4.mvadj_cur", 32'(cursor), 32'b001);
        check_all("t4");

        // 5. frozen time, blink period, full first second after exit
        tog_n = 0; tog_a = 0; tog_b = 0; pb = blink;
        for (int i = 1; i <= 2 * HALF; i++) begin
            cyc();
            if (blink !== pb) begin
                tog_n++;
                if (tog_n == 1) tog_a = i;
                else if (tog_n == 2) tog_b = i;
            end
            pb = blink;
        end
        chk("t5.toggles", 32'(tog_n), 32'd2);
        chk("t5.period", 32'(tog_b - tog_a), 32'(HALF));
        chk("t5.frozen_sec", 32'(sec), 32'd59);
        chk("t5.frozen_hour", 32'(hour), 32'd0);
        check_all("t5set");
        sw_set = 1'b0; cyc();
        chk("t5.run_blink", 32'(blink), 32'd1);
        wait_n = 0;
        for (int i = 0; i < 2 * CLK_HZ; i++) begin
            prev_sec = sec;
            cyc();
            wait_n++;
            if (sec !== prev_sec) break;
        end
        chk("t5.first_sec", 32'(wait_n), 32'(CLK_HZ));
        check_all("t5run");

        // randomized button traffic in SET, then a random RUN stretch
        sw_set = 1'b1; cyc();
        for (int i = 0; i < 150; i++) begin
            rb = 4'($urandom_range(0, 15));
            press(rb[0], rb[1], rb[2], rb[3]);
            check_all("rnd_set");
        end
        sw_set = 1'b0; cyc();
        repeat ($urandom_range(50, 400)) begin
            rb = 4'($urandom_range(0, 15));
            press(rb[0], rb[1], rb[2], rb[3]);
        end
        check_all("rnd_run");

        // 6. reset mid-SET while an up pulse is live
        sw_set = 1'b1; cyc();
        press(0, 1, 0, 0);
        btn_up = 1'b1;
        rst = 1'b0;
        #1;
        chk("t6.hour", 32'(hour), 32'd12);
        chk("t6.sec", 32'(sec), 32'd0);
        chk("t6.cursor", 32'(cursor), 32'd0);
        chk("t6.blink", 32'(blink), 32'd1);
        @(posedge clk); #1;
        chk("t6.hold_hour", 32'(hour), 32'd12);
        chk("t6.hold_min", 32'(min), 32'd0);
        chk("t6.hold_sub", 32'(subsec), 32'd0);
        model_reset();
        check_all("t6");
        btn_up = 1'b0; sw_set = 1'b0;
        rst = 1'b1;
        repeat (5) cyc();
        check_all("t6post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
